// File: rtl/cursor_key_repeat.sv
// Arrow-button conditioner: synchronize and debounce four raw buttons, then
// arbitrate to one owning direction and emit one-cycle step pulses with auto-repeat.
module cursor_key_repeat #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 19500000,
    parameter int REPEAT_PERIOD   = 3250000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic held
);

    // Lane order doubles as arbitration priority: lane 0 wins simultaneous rises.
    localparam int LANE_DOWN  = 0;
    localparam int LANE_UP    = 1;
    localparam int LANE_LEFT  = 2;
    localparam int LANE_RIGHT = 3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // The FIRST state already spends one cycle of the delay before r starts counting.
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 2);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        DELAY  = 2'd2,
        REPEAT = 2'd3
    } state_t;

    logic [3:0]            raw;
    logic [3:0]            sync1_q;
    logic [3:0]            sync2_q;
    logic [3:0]            db_q;
    logic [3:0]            db_d;
    logic [3:0]            db_prev_q;
    logic [3:0][CNT_W-1:0] dbc_q;
    logic [3:0][CNT_W-1:0] dbc_d;

    state_t                state_q;
    logic [1:0]            dir_q;
    logic [CNT_W-1:0]      r_q;
    logic [3:0]            pulse_q;
    logic                  held_q;

    logic [3:0]            rise;
    logic                  rise_any;
    logic [1:0]            rise_dir;
    logic                  owner_db;
    logic                  owner_db_next;

    assign raw = {btn_right, btn_left, btn_up, btn_down};

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES steady samples.
    always_comb begin
        db_d  = db_q;
        dbc_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (dbc_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            dbc_q     <= '0;
            db_prev_q <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            dbc_q     <= dbc_d;
            db_prev_q <= db_q;
        end
    end

    assign rise     = db_q & ~db_prev_q;
    assign rise_any = |rise;

    always_comb begin
        rise_dir = 2'(LANE_RIGHT);
        if (rise[LANE_DOWN]) begin
            rise_dir = 2'(LANE_DOWN);
        end else if (rise[LANE_UP]) begin
            rise_dir = 2'(LANE_UP);
        end else if (rise[LANE_LEFT]) begin
            rise_dir = 2'(LANE_LEFT);
        end
    end

    // The next debounced level lets us drop a pulse that would land in the cycle db falls.
    assign owner_db      = db_q[dir_q];
    assign owner_db_next = db_d[dir_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= '0;
            r_q     <= '0;
            pulse_q <= '0;
            held_q  <= 1'b0;
        end else begin
            pulse_q <= '0;
            case (state_q)
                IDLE: begin
                    if (rise_any) begin
                        state_q  <= FIRST;
                        dir_q    <= rise_dir;
                        pulse_q  <= 4'b0001 << rise_dir;
                        held_q   <= 1'b1;
                    end
                end
                FIRST: begin
                    r_q     <= '0;
                    state_q <= DELAY;
                end
                DELAY: begin
                    if (!owner_db) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                    end else if (r_q == DLY_LAST) begin
                        if (owner_db_next) begin
                            pulse_q <= 4'b0001 << dir_q;
                        end
                        r_q     <= '0;
                        state_q <= REPEAT;
                    end else begin
                        r_q <= r_q + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (!owner_db) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                    end else if (r_q == PER_LAST) begin
                        if (owner_db_next) begin
                            pulse_q <= 4'b0001 << dir_q;
                        end
                        r_q <= '0;
                    end else begin
                        r_q <= r_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign down  = pulse_q[LANE_DOWN];
    assign up    = pulse_q[LANE_UP];
    assign left  = pulse_q[LANE_LEFT];
    assign right = pulse_q[LANE_RIGHT];
    assign held  = held_q;

endmodule
